// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan code decoder: pops bytes from an upstream FIFO, tracks
// make/break/extended prefixes and modifier state, and emits ASCII for mapped keys.
module ps2_scancode_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             fpga_clk,
    input  logic             reset,
    input  logic [7:0]       kb_data,
    input  logic             kb_ready,
    input  logic             kb_overflow,
    output logic             kb_read,
    output logic [7:0]       ascii,
    output logic             ascii_valid,
    output logic [7:0]       key_code,
    output logic             key_down,
    output logic             extended,
    output logic             shift,
    output logic             caps,
    output logic [CNT_W-1:0] press_count,
    output logic             overflow_seen
);

    typedef enum logic [1:0] {ST_IDLE, ST_POP, ST_PROC} state_t;

    state_t           r_state, w_state_next;
    logic [7:0]       r_byte, w_byte_next;
    logic             r_ext_pend, w_ext_pend_next;
    logic             r_brk_pend, w_brk_pend_next;
    logic             r_shift_l, w_shift_l_next;
    logic             r_shift_r, w_shift_r_next;
    logic             r_caps, w_caps_next;
    logic             r_caps_held, w_caps_held_next;
    logic [7:0]       r_key_code, w_key_code_next;
    logic             r_key_down, w_key_down_next;
    logic             r_extended, w_extended_next;
    logic [7:0]       r_ascii, w_ascii_next;
    logic             r_ascii_valid, w_ascii_valid_next;
    logic [CNT_W-1:0] r_press_count, w_press_count_next;
    logic             r_overflow_seen, w_overflow_seen_next;
    logic             w_kb_read;
    logic [7:0]       w_letter;
    logic [7:0]       w_other;

    // Lowercase ASCII for letter keys, 0 when the code is not a letter.
    function automatic logic [7:0] f_letter(input logic [7:0] code);
        case (code)
            8'h1C: f_letter = 8'h61;  8'h32: f_letter = 8'h62;
            8'h21: f_letter = 8'h63;  8'h23: f_letter = 8'h64;
            8'h24: f_letter = 8'h65;  8'h2B: f_letter = 8'h66;
            8'h34: f_letter = 8'h67;  8'h33: f_letter = 8'h68;
            8'h43: f_letter = 8'h69;  8'h3B: f_letter = 8'h6A;
            8'h42: f_letter = 8'h6B;  8'h4B: f_letter = 8'h6C;
            8'h3A: f_letter = 8'h6D;  8'h31: f_letter = 8'h6E;
            8'h44: f_letter = 8'h6F;  8'h4D: f_letter = 8'h70;
            8'h15: f_letter = 8'h71;  8'h2D: f_letter = 8'h72;
            8'h1B: f_letter = 8'h73;  8'h2C: f_letter = 8'h74;
            8'h3C: f_letter = 8'h75;  8'h2A: f_letter = 8'h76;
            8'h1D: f_letter = 8'h77;  8'h22: f_letter = 8'h78;
            8'h35: f_letter = 8'h79;  8'h1A: f_letter = 8'h7A;
            default: f_letter = 8'h00;
        endcase
    endfunction

    // Digits and control keys; these ignore shift and caps.
    function automatic logic [7:0] f_other(input logic [7:0] code);
        case (code)
            8'h45: f_other = 8'h30;  8'h16: f_other = 8'h31;
            8'h1E: f_other = 8'h32;  8'h26: f_other = 8'h33;
            8'h25: f_other = 8'h34;  8'h2E: f_other = 8'h35;
            8'h36: f_other = 8'h36;  8'h3D: f_other = 8'h37;
            8'h3E: f_other = 8'h38;  8'h46: f_other = 8'h39;
            8'h29: f_other = 8'h20;  8'h5A: f_other = 8'h0D;
            8'h66: f_other = 8'h08;
            default: f_other = 8'h00;
        endcase
    endfunction

    assign w_letter = f_letter(r_byte);
    assign w_other  = f_other(r_byte);

    always_ff @(posedge fpga_clk) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_byte          <= 8'h00;
            r_ext_pend      <= 1'b0;
            r_brk_pend      <= 1'b0;
            r_shift_l       <= 1'b0;
            r_shift_r       <= 1'b0;
            r_caps          <= 1'b0;
            r_caps_held     <= 1'b0;
            r_key_code      <= 8'h00;
            r_key_down      <= 1'b0;
            r_extended      <= 1'b0;
            r_ascii         <= 8'h00;
            r_ascii_valid   <= 1'b0;
            r_press_count   <= '0;
            r_overflow_seen <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_byte          <= w_byte_next;
            r_ext_pend      <= w_ext_pend_next;
            r_brk_pend      <= w_brk_pend_next;
            r_shift_l       <= w_shift_l_next;
            r_shift_r       <= w_shift_r_next;
            r_caps          <= w_caps_next;
            r_caps_held     <= w_caps_held_next;
            r_key_code      <= w_key_code_next;
            r_key_down      <= w_key_down_next;
            r_extended      <= w_extended_next;
            r_ascii         <= w_ascii_next;
            r_ascii_valid   <= w_ascii_valid_next;
            r_press_count   <= w_press_count_next;
            r_overflow_seen <= w_overflow_seen_next;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        w_byte_next          = r_byte;
        w_ext_pend_next      = r_ext_pend;
        w_brk_pend_next      = r_brk_pend;
        w_shift_l_next       = r_shift_l;
        w_shift_r_next       = r_shift_r;
        w_caps_next          = r_caps;
        w_caps_held_next     = r_caps_held;
        w_key_code_next      = r_key_code;
        w_key_down_next      = r_key_down;
        w_extended_next      = r_extended;
        w_ascii_next         = r_ascii;
        w_ascii_valid_next   = 1'b0;
        w_press_count_next   = r_press_count;
        w_overflow_seen_next = r_overflow_seen | kb_overflow;
        w_kb_read            = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (kb_ready) w_state_next = ST_POP;
            end
            ST_POP: begin
                w_kb_read    = 1'b1;
                w_byte_next  = kb_data;
                w_state_next = ST_PROC;
            end
            ST_PROC: begin
                w_state_next = ST_IDLE;
                if (r_byte == 8'hE0) begin
                    w_ext_pend_next = 1'b1;
                end else if (r_byte == 8'hF0) begin
                    w_brk_pend_next = 1'b1;
                end else begin
                    w_ext_pend_next = 1'b0;
                    w_brk_pend_next = 1'b0;
                    if (!r_brk_pend) begin
                        w_key_code_next = r_byte;
                        w_extended_next = r_ext_pend;
                        w_key_down_next = 1'b1;
                        // A held key re-sending its code is typematic, not a new press.
                        if (!(r_key_down && r_byte == r_key_code))
                            w_press_count_next = r_press_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (!r_ext_pend && r_byte == 8'h12) w_shift_l_next = 1'b1;
                        if (!r_ext_pend && r_byte == 8'h59) w_shift_r_next = 1'b1;
                        if (r_byte == 8'h58) begin
                            if (!r_caps_held) w_caps_next = ~r_caps;
                            w_caps_held_next = 1'b1;
                        end
                        if (!r_ext_pend && w_letter != 8'h00) begin
                            w_ascii_valid_next = 1'b1;
                            w_ascii_next = ((r_shift_l | r_shift_r) ^ r_caps)
                                           ? (w_letter - 8'h20) : w_letter;
                        end else if (!r_ext_pend && w_other != 8'h00) begin
                            w_ascii_valid_next = 1'b1;
                            w_ascii_next       = w_other;
                        end
                    end else begin
                        if (r_byte == r_key_code && r_ext_pend == r_extended)
                            w_key_down_next = 1'b0;
                        if (!r_ext_pend && r_byte == 8'h12) w_shift_l_next = 1'b0;
                        if (!r_ext_pend && r_byte == 8'h59) w_shift_r_next = 1'b0;
                        if (r_byte == 8'h58) w_caps_held_next = 1'b0;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign kb_read       = w_kb_read;
    assign ascii         = r_ascii;
    assign ascii_valid   = r_ascii_valid;
    assign key_code      = r_key_code;
    assign key_down      = r_key_down;
    assign extended      = r_extended;
    assign shift         = r_shift_l | r_shift_r;
    assign caps          = r_caps;
    assign press_count   = r_press_count;
    assign overflow_seen = r_overflow_seen;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: a queue stands in for the upstream
// FIFO and each step compares outputs against hand-computed values.
module tb_ps2_scancode_decoder;

    logic       fpga_clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_ready = 1'b0;
    logic       kb_overflow = 1'b0;
    logic       kb_read;
    logic [7:0] ascii;
    logic       ascii_valid;
    logic [7:0] key_code;
    logic       key_down;
    logic       extended;
    logic       shift;
    logic       caps;
    logic [7:0] press_count;
    logic       overflow_seen;

    ps2_scancode_decoder #(.CNT_W(8)) dut (
        .fpga_clk     (fpga_clk),
        .reset        (reset),
        .kb_data      (kb_data),
        .kb_ready     (kb_ready),
        .kb_overflow  (kb_overflow),
        .kb_read      (kb_read),
        .ascii        (ascii),
        .ascii_valid  (ascii_valid),
        .key_code     (key_code),
        .key_down     (key_down),
        .extended     (extended),
        .shift        (shift),
        .caps         (caps),
        .press_count  (press_count),
        .overflow_seen(overflow_seen)
    );

    initial forever #5 fpga_clk = ~fpga_clk;

    logic [7:0] fifo_q[$];
    int         cyc = 0;
    int         av_cnt = 0;
    int         rd_cnt = 0;
    int         rd_times[$];
    bit         pop_due = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic refresh_if();
        kb_ready = (fifo_q.size() != 0);
        kb_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    always @(posedge fpga_clk) cyc++;

    // Upstream FIFO model: a pop seen during POP takes effect one cycle later,
    // after the DUT has latched the head byte.
    always @(negedge fpga_clk) begin
        if (pop_due) begin
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            pop_due = 0;
            refresh_if();
        end
        if (kb_read) begin
            pop_due = 1;
            rd_cnt++;
            rd_times.push_back(cyc);
        end
        if (ascii_valid) av_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        refresh_if();
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && fifo_q.size() != 0; i++) @(negedge fpga_clk);
        if (fifo_q.size() != 0) check("drain_timeout", fifo_q.size(), 0);
        repeat (4) @(negedge fpga_clk);
    endtask

    task automatic key(input logic [7:0] b);
        push(b);
        drain();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge fpga_clk);
        reset = 1'b1;
        @(negedge fpga_clk);
    endtask

    int av_base;
    int rd_base;

    initial begin
        do_reset();
        check("rst_kb_read", kb_read, 0);
        check("rst_ascii", ascii, 0);
        check("rst_ascii_valid", ascii_valid, 0);
        check("rst_key_code", key_code, 0);
        check("rst_flags", {key_down, extended, shift, caps, overflow_seen}, 0);
        check("rst_press_count", press_count, 0);

        // Plain 'a' press and release
        av_base = av_cnt;
        key(8'h1C);
        check("a_ascii", ascii, 8'h61);
        check("a_key_down", key_down, 1);
        check("a_key_code", key_code, 8'h1C);
        key(8'hF0); key(8'h1C);
        check("a_rel_key_down", key_down, 0);
        check("a_av_count", av_cnt - av_base, 1);
        check("a_press_count", press_count, 1);

        // Shifted 'A'
        do_reset();
        av_base = av_cnt;
        key(8'h12);
        check("sh_shift_on", shift, 1);
        key(8'h1C);
        check("sh_ascii", ascii, 8'h41);
        key(8'hF0); key(8'h1C); key(8'hF0); key(8'h12);
        check("sh_shift_off", shift, 0);
        check("sh_av_count", av_cnt - av_base, 1);
        check("sh_press_count", press_count, 2);

        // Caps lock toggling and held-key suppression
        do_reset();
        av_base = av_cnt;
        key(8'h58); key(8'hF0); key(8'h58); key(8'h1C);
        check("caps_on", caps, 1);
        check("caps_ascii", ascii, 8'h41);
        check("caps_av_count", av_cnt - av_base, 1);
        key(8'h58); key(8'hF0); key(8'h58);
        check("caps_off", caps, 0);
        key(8'h58); key(8'h58);
        check("caps_single_toggle", caps, 1);
        check("caps_press_count", press_count, 4);

        // Extended key, plus a break whose prefix does not match
        do_reset();
        av_base = av_cnt;
        key(8'hE0); key(8'h75);
        check("ext_extended", extended, 1);
        check("ext_key_code", key_code, 8'h75);
        check("ext_key_down", key_down, 1);
        key(8'hF0); key(8'h75);
        check("ext_plain_break_ignored", key_down, 1);
        key(8'hE0); key(8'hF0); key(8'h75);
        check("ext_key_up", key_down, 0);
        check("ext_no_ascii", av_cnt - av_base, 0);

        // Back-to-back queued bytes: pop spacing and typematic repeats
        do_reset();
        av_base = av_cnt;
        rd_base = rd_cnt;
        push(8'h1C); push(8'h1C); push(8'h1C);
        drain();
        check("q_read_count", rd_cnt - rd_base, 3);
        if (rd_cnt - rd_base == 3) begin
            check("q_gap1", rd_times[rd_base + 1] - rd_times[rd_base], 3);
            check("q_gap2", rd_times[rd_base + 2] - rd_times[rd_base + 1], 3);
        end
        check("q_av_count", av_cnt - av_base, 3);
        check("q_press_count", press_count, 1);

        // Reset clears a pending break prefix
        do_reset();
        key(8'hF0);
        reset = 1'b0;
        @(negedge fpga_clk);
        reset = 1'b1;
        @(negedge fpga_clk);
        key(8'h1C);
        check("rb_ascii", ascii, 8'h61);
        check("rb_key_down", key_down, 1);
        check("rb_press_count", press_count, 1);

        // Reset during POP discards the byte; the pop is not repeated
        do_reset();
        av_base = av_cnt;
        rd_base = rd_cnt;
        push(8'h1C);
        for (int i = 0; i < 20 && !kb_read; i++) @(negedge fpga_clk);
        check("mid_saw_read", kb_read, 1);
        reset = 1'b0;
        @(negedge fpga_clk);
        reset = 1'b1;
        repeat (6) @(negedge fpga_clk);
        check("mid_reads", rd_cnt - rd_base, 1);
        check("mid_no_ascii", av_cnt - av_base, 0);
        check("mid_press_count", press_count, 0);
        check("mid_key_down", key_down, 0);

        // Digits, controls, right shift, typematic repeat, unmapped, caps^shift
        do_reset();
        av_base = av_cnt;
        key(8'h12); key(8'h16);
        check("d_one_shifted", ascii, 8'h31);
        key(8'h59); key(8'hF0); key(8'h12);
        check("d_rshift_held", shift, 1);
        key(8'h4D);
        check("d_P_upper", ascii, 8'h50);
        key(8'hF0); key(8'h59);
        check("d_shift_released", shift, 0);
        key(8'h4D);
        check("d_p_repeat_lower", ascii, 8'h70);
        key(8'h29);
        check("d_space", ascii, 8'h20);
        key(8'h5A);
        check("d_enter", ascii, 8'h0D);
        key(8'h66);
        check("d_backspace", ascii, 8'h08);
        key(8'h05);
        check("d_unmapped_hold", ascii, 8'h08);
        key(8'h58); key(8'h12); key(8'h1A);
        check("d_caps_shift_z", ascii, 8'h7A);
        check("d_av_count", av_cnt - av_base, 7);
        check("d_press_count", press_count, 11);

        // Sticky overflow flag
        check("ov_clear", overflow_seen, 0);
        kb_overflow = 1'b1;
        @(negedge fpga_clk);
        kb_overflow = 1'b0;
        repeat (3) @(negedge fpga_clk);
        check("ov_sticky", overflow_seen, 1);
        do_reset();
        check("ov_reset", overflow_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of press_count.
REQ-002 SHALL have port fpga_clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have port kb_data  in  8  byte at the head of the upstream keyboard FIFO, valid combinationally while kb_ready=1.
REQ-005 SHALL have port kb_ready  in  1  upstream FIFO non-empty.
REQ-006 SHALL have port kb_overflow  in  1  upstream FIFO overflow flag.
REQ-007 SHALL have port kb_read  out  1  one-cycle pop strobe to upstream.
REQ-008 SHALL have port ascii  out  8  last decoded ASCII character.
REQ-009 SHALL have port ascii_valid  out  1  one-cycle pulse when ascii is updated.
REQ-010 SHALL have port key_code  out  8  scan code of the last make event.
REQ-011 SHALL have port key_down  out  1  level: the key in key_code is held.
REQ-012 SHALL have port extended  out  1  last make event carried the E0 prefix.
REQ-013 SHALL have port shift  out  1  left (0x12) or right (0x59) shift held.
REQ-014 SHALL have port caps  out  1  caps-lock toggle state.
REQ-015 SHALL have port press_count  out  CNT_W  count of new key presses, wraps modulo 2^CNT_W.
REQ-016 SHALL have port overflow_seen  out  1  sticky copy of kb_overflow.

Function
REQ-017 SHALL use FSM IDLE -> POP -> PROC -> IDLE; IDLE moves to POP when kb_ready=1, else stays.
REQ-018 In POP SHALL drive kb_read=1 for exactly that cycle and latch kb_data into byte_r; kb_read SHALL be 0 in all other states.
REQ-019 In PROC SHALL decode byte_r and update outputs at the end of that cycle; pops are therefore at least 3 cycles apart, and kb_ready is not sampled in PROC.
REQ-020 byte 0xE0 SHALL set ext_pend; byte 0xF0 SHALL set brk_pend; neither produces any other output change.
REQ-021 Any other byte SHALL be a make if brk_pend=0, a break if brk_pend=1; ext_pend and brk_pend SHALL both clear after it.
REQ-022 Make: key_code<=byte, extended<=ext_pend, key_down<=1; press_count SHALL increment unless key_down=1 and byte==key_code (typematic repeat).
REQ-023 Break: key_down<=0 only if byte==key_code and ext_pend==extended; otherwise key_down unchanged.
REQ-024 Non-extended make/break of 0x12 or 0x59 SHALL set/clear that shift bit; shift output is the OR of both bits.
REQ-025 Make of 0x58 SHALL toggle caps only when caps_held=0, then set caps_held; break of 0x58 clears caps_held.
REQ-026 Non-extended make of a mapped code SHALL pulse ascii_valid with ascii, including typematic repeats; breaks, extended makes, modifiers and unmapped codes SHALL NOT pulse.
REQ-027 Letter map: 1C A,32 B,21 C,23 D,24 E,2B F,34 G,33 H,43 I,3B J,42 K,4B L,3A M,31 N,44 O,4D P,15 Q,2D R,1B S,2C T,3C U,2A V,1D W,22 X,35 Y,1A Z; uppercase when shift XOR caps, else lowercase.
REQ-028 Digit map: 45 '0',16 '1',1E '2',26 '3',25 '4',2E '5',36 '6',3D '7',3E '8',46 '9', unaffected by shift/caps; 29->0x20, 5A->0x0D, 66->0x08.
REQ-029 overflow_seen SHALL set on any cycle with kb_overflow=1 and clear only on reset.

Reset
REQ-030 With reset=0 at a clock edge SHALL enter IDLE and clear kb_read, ascii, ascii_valid, key_code, key_down, extended, shift bits, caps, caps_held, press_count, overflow_seen, ext_pend, brk_pend, byte_r to 0.
REQ-031 Reset in POP or PROC SHALL discard the byte in flight; the upstream pop already issued is not repeated.

Verification
REQ-032 Bytes 1C,F0,1C -> one ascii_valid with ascii=0x61; key_down 1 then 0; press_count=1.
REQ-033 Bytes 12,1C,F0,1C,F0,12 -> one ascii_valid, ascii=0x41; shift 1 then 0.
REQ-034 Bytes 58,F0,58,1C -> caps=1, ascii=0x41; then 58,F0,58 -> caps=0; 58,58 without break -> single toggle.
REQ-035 Bytes E0,75,E0,F0,75 -> no ascii_valid; extended=1, key_code=0x75, key_down 1 then 0.
REQ-036 kb_ready high over 3 queued bytes 1C,1C,1C -> exactly 3 kb_read pulses, 3 cycles apart; 3 ascii_valid; press_count=1.
REQ-037 F0 popped, reset low one cycle, then 1C -> treated as make: ascii=0x61, key_down=1, press_count=1.
